// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control stage: PS/2 set-2 key codes
// and the FSM state encoding (also driven out on the debug `state` port).
package stopwatch_pkg;

    localparam logic [7:0] KEY_S   = 8'h1B;
    localparam logic [7:0] KEY_L   = 8'h4B;
    localparam logic [7:0] KEY_R   = 8'h2D;
    localparam logic [7:0] KEY_BRK = 8'hF0;
    localparam logic [7:0] KEY_EXT = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

endpackage

// File: rtl/stopwatch_ctrl_prescaler.sv
// tick_prescaler: divides clk by DIV. Counts while en, holds otherwise,
// clr forces the count to zero and wins over en. tick is a decode of the
// registered count, so it never depends combinationally on en's source keys.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   TERM = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, wrap at DIV-1, or hold while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == TERM);

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: PS/2 key filter, start/pause/lap/clear FSM and tick
// prescaler feeding the counter chain.
// Build option: define STOPWATCH_LAP_EN to enable the LAP state and lap_hold;
// without it L is ignored, LAP is unreachable and lap_hold is tied low.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | cleared, prescaler held at 0
// RUN   | counting, display live
// PAUSE | counting stopped, prescaler phase preserved
// LAP   | counting, display frozen (lap_hold)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       inc,
    output logic       is_reset,
    output logic       running,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    state_t state_q, state_d;
    logic   brk_q, brk_d;
    logic   is_reset_q, is_reset_d;
    logic   key_s, key_r;
`ifdef STOPWATCH_LAP_EN
    logic   key_l;
`endif
    logic   r_accept;

    // Key filter: E0 is transparent, a byte following F0 is swallowed.
    always_comb begin
        brk_d = brk_q;
        key_s = 1'b0;
        key_r = 1'b0;
`ifdef STOPWATCH_LAP_EN
        key_l = 1'b0;
`endif
        if (key_valid && key_code != KEY_EXT) begin
            if (brk_q) begin
                brk_d = 1'b0;
            end else if (key_code == KEY_BRK) begin
                brk_d = 1'b1;
            end else begin
                key_s = (key_code == KEY_S);
                key_r = (key_code == KEY_R);
`ifdef STOPWATCH_LAP_EN
                key_l = (key_code == KEY_L);
`endif
            end
        end
    end

    // Next-state logic; R is only honoured where the counter is stopped.
    always_comb begin
        state_d  = state_q;
        r_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_s) begin
                    state_d = ST_RUN;
                end else if (key_r) begin
                    r_accept = 1'b1;
                end
            end
            ST_RUN: begin
                if (key_s) begin
                    state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (key_l) begin
                    state_d = ST_LAP;
`endif
                end
            end
            ST_PAUSE: begin
                if (key_s) begin
                    state_d = ST_RUN;
                end else if (key_r) begin
                    state_d  = ST_IDLE;
                    r_accept = 1'b1;
                end
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (key_s) begin
                    state_d = ST_PAUSE;
                end else if (key_l) begin
                    state_d = ST_RUN;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        is_reset_d = r_accept;
    end

    // State, break flag and clear-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            brk_q      <= 1'b0;
            is_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            brk_q      <= brk_d;
            is_reset_q <= is_reset_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        state    = state_q;
        running  = state_q[0];
        is_reset = is_reset_q;
`ifdef STOPWATCH_LAP_EN
        lap_hold = (state_q == ST_LAP);
`else
        lap_hold = 1'b0;
`endif
    end

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q[0]),
        .clr   ((state_q == ST_IDLE) || r_accept),
        .tick  (inc)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (DIV = 10). The driver advances a
// behavioural model once per cycle and queues the expected state and the
// cycle numbers of expected inc / is_reset pulses; the monitor pops and
// compares whenever the DUT shows them.
module tb_stopwatch_ctrl;

    localparam int DIV = 10;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       inc, is_reset, running, lap_hold;
    logic [1:0] state;

    stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .inc       (inc),
        .is_reset  (is_reset),
        .running   (running),
        .lap_hold  (lap_hold),
        .state     (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int         exp_inc_q[$];
    int         exp_rst_q[$];
    logic [1:0] exp_st_q[$];

    // reference model: stopwatch started? counting? display frozen?
    bit m_started = 0, m_running = 0, m_lap = 0, m_brk = 0, m_rst_pend = 0;
    int m_cnt = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] model_state();
        if (!m_started) return 2'd0;
        if (m_lap)      return 2'd3;
        if (m_running)  return 2'd1;
        return 2'd2;
    endfunction

    // Drive one cycle's inputs and advance the model across the next edge.
    task automatic cycle_body(bit v, logic [7:0] code);
        bit s, l, r;
        key_valid = v;
        key_code  = code;
        exp_st_q.push_back(model_state());
        if (m_running && m_cnt == DIV - 1) exp_inc_q.push_back(cyc);
        if (m_rst_pend) exp_rst_q.push_back(cyc);
        m_rst_pend = 0;
        s = 0; l = 0; r = 0;
        if (v && code != 8'hE0) begin
            if (m_brk)              m_brk = 0;
            else if (code == 8'hF0) m_brk = 1;
            else begin
                s = (code == 8'h1B);
                l = (code == 8'h4B);
                r = (code == 8'h2D);
            end
        end
        if (!m_started)     m_cnt = 0;
        else if (m_running) m_cnt = (m_cnt + 1) % DIV;
        if (s) begin
            if (!m_started)     begin m_started = 1; m_running = 1; end
            else if (m_running) begin m_running = 0; m_lap = 0; end
            else                m_running = 1;
        end else if (l && LAP_EN && m_running) begin
            m_lap = !m_lap;
        end else if (r && !m_running) begin
            m_started  = 0;
            m_cnt      = 0;
            m_rst_pend = 1;
        end
    endtask

    task automatic step(bit v, logic [7:0] code);
        @(negedge clk);
        cycle_body(v, code);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic run_until_cnt(int target);
        for (int i = 0; i < 3 * DIV && m_cnt != target; i++) step(1'b0, 8'h00);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle_body(1'b0, 8'h00);
    endtask

    // Monitor: compare every cycle's state, and pulses as they appear.
    logic [1:0] mon_e;
    int         mon_c;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (exp_st_q.size() > 0) begin
                    mon_e = exp_st_q.pop_front();
                    check("state", state, mon_e);
                    check("running", running, (mon_e == 2'd1 || mon_e == 2'd3));
                    check("lap_hold", lap_hold, (mon_e == 2'd3));
                end
                check("inc_and_is_reset_overlap", inc & is_reset, 0);
                if (inc) begin
                    check("inc_expected", exp_inc_q.size() > 0, 1);
                    if (exp_inc_q.size() > 0) begin
                        mon_c = exp_inc_q.pop_front();
                        check("inc_cycle", cyc, mon_c);
                    end
                end
                if (is_reset) begin
                    check("is_reset_expected", exp_rst_q.size() > 0, 1);
                    if (exp_rst_q.size() > 0) begin
                        mon_c = exp_rst_q.pop_front();
                        check("is_reset_cycle", cyc, mon_c);
                    end
                end
            end
        end
    end

    initial begin
        int  sel;
        logic [7:0] code;

        #2;
        check("reset_state", state, 0);
        check("reset_inc", inc, 0);
        check("reset_is_reset", is_reset, 0);
        check("reset_running", running, 0);
        check("reset_lap_hold", lap_hold, 0);
        repeat (2) @(negedge clk);
        release_reset();
        idle(3);

        // start, three ticks
        step(1'b1, 8'h1B);
        idle(32);
        // break code then S: discarded
        step(1'b1, 8'hF0);
        step(1'b1, 8'h1B);
        idle(12);
        // extended prefix is transparent to brk
        step(1'b1, 8'hE0);
        idle(3);
        // pause with prescaler held at 4, long idle, resume
        run_until_cnt(3);
        step(1'b1, 8'h1B);
        idle(50);
        step(1'b1, 8'h1B);
        idle(12);
        // R in RUN ignored; pause then clear
        step(1'b1, 8'h2D);
        idle(3);
        step(1'b1, 8'h1B);
        step(1'b1, 8'h2D);
        idle(15);
        // stop on the tick cycle: tick still delivered, phase wraps to 0
        step(1'b1, 8'h1B);
        run_until_cnt(DIV - 1);
        step(1'b1, 8'h1B);
        idle(5);
        step(1'b1, 8'h1B);
        idle(12);
        // lap on the tick cycle, hold across ticks, release, lap then stop
        run_until_cnt(DIV - 1);
        step(1'b1, 8'h4B);
        idle(13);
        step(1'b1, 8'h4B);
        idle(5);
        step(1'b1, 8'h4B);
        step(1'b1, 8'h1B);
        step(1'b1, 8'h2D);
        step(1'b1, 8'h2D);
        idle(4);

        // random keys against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1, 2: code = 8'h1B;
                    3, 4:    code = 8'h4B;
                    5:       code = 8'h2D;
                    6:       code = 8'hF0;
                    7:       code = 8'hE0;
                    default: code = 8'($urandom_range(0, 255));
                endcase
                step(1'b1, code);
            end else begin
                step(1'b0, 8'h00);
            end
        end

        // asynchronous reset mid-RUN
        step(1'b1, 8'h00);
        if (!m_running) step(1'b1, 8'h1B);
        idle(7);
        step(1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_inc", inc, 0);
        check("async_rst_is_reset", is_reset, 0);
        check("async_rst_running", running, 0);
        check("async_rst_lap_hold", lap_hold, 0);
        m_started = 0; m_running = 0; m_lap = 0; m_brk = 0; m_rst_pend = 0; m_cnt = 0;
        exp_inc_q.delete();
        exp_rst_q.delete();
        exp_st_q.delete();
        repeat (2) @(negedge clk);
        release_reset();
        idle(15);

        @(negedge clk);
        #3;
        check("inc_queue_drained", exp_inc_q.size(), 0);
        check("is_reset_queue_drained", exp_rst_q.size(), 0);
        check("state_queue_drained", exp_st_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
